// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and the
// fill value used for invalid-op and divide-by-zero results.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_NE   = 4'b0010;
  localparam logic [OP_W-1:0] ALU_GT   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_LT   = 4'b0100;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_MULT = 4'b1000;
  localparam logic [OP_W-1:0] ALU_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  // Replicated across the full result width for invalid / div-by-zero lo.
  localparam logic INVALID_FILL = 1'b1;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per
// enabled cycle.
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture operands and mode (a = multiplicand/dividend,
//                  b = multiplier/divisor)
//   en           : perform one step
//   mul          : 1 = multiply, 0 = divide (sampled on load)
//   hi_nxt_c     : accumulator/remainder after the step in progress
//   lo_nxt_c     : product-low/quotient after the step in progress
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt_c,
  output logic [WIDTH-1:0] lo_nxt_c
);

  logic [WIDTH-1:0] hi_q;    // accumulator / partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] opnd_q;  // multiplicand / divisor
  logic             mul_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;

  // One step of the selected algorithm.
  always_comb begin
    hi_nxt_c = hi_q;
    lo_nxt_c = lo_q;
    sum      = '0;
    shifted  = '0;
    if (mul_q) begin
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      {hi_nxt_c, lo_nxt_c} = {sum, lo_q[WIDTH-1:1]};
    end else begin
      shifted = {hi_q, lo_q[WIDTH-1]};
      if (shifted >= {1'b0, opnd_q}) begin
        hi_nxt_c = WIDTH'(shifted - {1'b0, opnd_q});
        lo_nxt_c = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_c = shifted[WIDTH-1:0];
        lo_nxt_c = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Operand capture and step registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mul_q  <= 1'b0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= mul ? b : a;
      opnd_q <= mul ? a : b;
      mul_q  <= mul;
    end else if (en) begin
      hi_q <= hi_nxt_c;
      lo_q <= lo_nxt_c;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops and
// invalid / div-by-zero cases finish in one cycle; MULT and DIV iterate
// WIDTH cycles in alu_iter_core.
//   clk, reset            : clock, synchronous active-high reset
//   start, op, a, b       : request, sampled only in IDLE
//   busy                  : high whenever not IDLE
//   done                  : one-cycle pulse, results valid from this cycle
//   result_lo, result_hi  : result / quotient, high product / remainder
//   div_by_zero, invalid_op : flags of the last completed op
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             invalid_op
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  alu_state_e       state;
  logic [CNT_W-1:0] cnt;

  logic             iter_mul_c;
  logic             iter_div_c;
  logic             core_load_c;
  logic             core_en_c;
  logic [WIDTH-1:0] core_hi_c;
  logic [WIDTH-1:0] core_lo_c;

  logic [WIDTH-1:0] sc_lo_c;
  logic [WIDTH-1:0] sc_hi_c;
  logic             sc_dbz_c;
  logic             sc_inv_c;

  assign iter_mul_c  = (op == ALU_MULT);
  assign iter_div_c  = (op == ALU_DIV) && (b != '0);
  assign core_load_c = (state == ST_IDLE) && start && (iter_mul_c || iter_div_c);
  assign core_en_c   = (state == ST_MUL) || (state == ST_DIV);

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load_c),
    .en       (core_en_c),
    .mul      (iter_mul_c),
    .a        (a),
    .b        (b),
    .hi_nxt_c (core_hi_c),
    .lo_nxt_c (core_lo_c)
  );

  // Results for everything that completes the cycle after acceptance.
  // The DIV arm is only used when b is zero.
  always_comb begin
    sc_lo_c  = '0;
    sc_hi_c  = '0;
    sc_dbz_c = 1'b0;
    sc_inv_c = 1'b0;
    case (op)
      ALU_ADD:  sc_lo_c = a + b;
      ALU_SUB:  sc_lo_c = a - b;
      ALU_NE:   sc_lo_c = WIDTH'(a != b);
      ALU_GT:   sc_lo_c = WIDTH'(a > b);
      ALU_LT:   sc_lo_c = WIDTH'(a < b);
      ALU_AND:  sc_lo_c = a & b;
      ALU_MULT: sc_lo_c = '0;
      ALU_DIV: begin
        sc_lo_c  = {WIDTH{INVALID_FILL}};
        sc_hi_c  = a;
        sc_dbz_c = 1'b1;
      end
      default: begin
        sc_lo_c  = {WIDTH{INVALID_FILL}};
        sc_inv_c = 1'b1;
      end
    endcase
  end

  // Control FSM with registered outputs; results load only on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
      invalid_op  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (iter_mul_c) begin
              state <= ST_MUL;
            end else if (iter_div_c) begin
              state <= ST_DIV;
            end else begin
              state       <= ST_DONE;
              done        <= 1'b1;
              result_lo   <= sc_lo_c;
              result_hi   <= sc_hi_c;
              div_by_zero <= sc_dbz_c;
              invalid_op  <= sc_inv_c;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          // This step is the WIDTH-th one; capture the core's final value.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            result_lo   <= core_lo_c;
            result_hi   <= core_hi_c;
            div_by_zero <= 1'b0;
            invalid_op  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop
// and compare on every done pulse (WIDTH = 32 and WIDTH = 8 instances).
module tb_alu_seq_unit;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    logic        inv;
    int          lat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [3:0]  op32 = 4'd0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dbz32, inv32;
  logic [31:0] lo32, hi32;

  logic        start8 = 1'b0;
  logic [3:0]  op8 = 4'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8, inv8;
  logic [7:0]  lo8, hi8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result_lo(lo32), .result_hi(hi32),
    .div_by_zero(dbz32), .invalid_op(inv32)
  );

  alu_seq_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .div_by_zero(dbz8), .invalid_op(inv8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi,
                              input logic dbz, input logic inv, input int lat);
    exp_t e;
    e.lo = lo; e.hi = hi; e.dbz = dbz; e.inv = inv; e.lat = lat; e.due = 0;
    return e;
  endfunction

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (!reset && done32) begin
      if (q32.size() == 0) begin
        chk("w32_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("w32_lo", lo32, e.lo);
        chk("w32_hi", hi32, e.hi);
        chk("w32_dbz", 32'(dbz32), 32'(e.dbz));
        chk("w32_inv", 32'(inv32), 32'(e.inv));
        chk("w32_done_cycle", 32'(cyc), 32'(e.due));
        chk("w32_busy_at_done", 32'(busy32), 32'd1);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_lo", {24'd0, lo8}, e.lo);
        chk("w8_hi", {24'd0, hi8}, e.hi);
        chk("w8_dbz", 32'(dbz8), 32'(e.dbz));
        chk("w8_done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue32(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input exp_t e, input bit push);
    int guard;
    guard = 0;
    while (busy32 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy32) chk("w32_idle_timeout", 32'(busy32), 32'd0);
    start32 = 1'b1; op32 = o; a32 = av; b32 = bv;
    e.due = cyc + e.lat;
    if (push) q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input exp_t e);
    int guard;
    guard = 0;
    while (busy8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy8) chk("w8_idle_timeout", 32'(busy8), 32'd0);
    start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
    e.due = cyc + e.lat;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_done", 32'(done32), 32'd0);
    chk("rst_lo", lo32, 32'd0);
    chk("rst_hi", hi32, 32'd0);
    chk("rst_flags", {30'd0, dbz32, inv32}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADD wraps; busy only in the DONE cycle.
    issue32(ALU_ADD, 32'hFFFF_FFFF, 32'd2, mk(32'h1, 32'h0, 1'b0, 1'b0, 1), 1'b1);
    chk("add_busy_t1", 32'(busy32), 32'd1);
    @(negedge clk);
    chk("add_busy_t2", 32'(busy32), 32'd0);

    // MULT with ignored start pulses and input changes while busy.
    issue32(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33), 1'b1);
    start32 = 1'b1; op32 = ALU_ADD; a32 = 32'd7; b32 = 32'd9;
    repeat (5) @(negedge clk);
    start32 = 1'b0;

    issue32(ALU_DIV, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0, 33), 1'b1);
    issue32(ALU_DIV, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1), 1'b1);
    issue32(4'b0101, 32'd3, 32'd9, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1), 1'b1);
    issue32(ALU_LT, 32'd3, 32'd9, mk(32'd1, 32'd0, 1'b0, 1'b0, 1), 1'b1);
    issue32(ALU_SUB, 32'd3, 32'd5, mk(32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1), 1'b1);
    issue32(ALU_NE, 32'd5, 32'd5, mk(32'd0, 32'd0, 1'b0, 1'b0, 1), 1'b1);
    issue32(ALU_GT, 32'd9, 32'd3, mk(32'd1, 32'd0, 1'b0, 1'b0, 1), 1'b1);
    issue32(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, mk(32'h0000_F000, 32'd0, 1'b0, 1'b0, 1), 1'b1);

    // Reset during cycle t+10 of a MULT aborts it without a done pulse.
    issue32(ALU_MULT, 32'd3, 32'd4, mk(32'd12, 32'd0, 1'b0, 1'b0, 33), 1'b0);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 32'(busy32), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy32), 32'd0);
    chk("abort_done", 32'(done32), 32'd0);
    chk("abort_lo", lo32, 32'd0);
    chk("abort_hi", hi32, 32'd0);
    chk("abort_flags", {30'd0, dbz32, inv32}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    issue32(ALU_ADD, 32'd1, 32'd1, mk(32'd2, 32'd0, 1'b0, 1'b0, 1), 1'b1);

    // WIDTH = 8 multi-cycle vectors: latency 9 each.
    issue8(ALU_MULT, 8'hFF, 8'hFF, mk(32'h01, 32'hFE, 1'b0, 1'b0, 9));
    issue8(ALU_MULT, 8'h12, 8'h34, mk(32'hA8, 32'h03, 1'b0, 1'b0, 9));
    issue8(ALU_MULT, 8'h80, 8'h02, mk(32'h00, 32'h01, 1'b0, 1'b0, 9));
    issue8(ALU_DIV, 8'hFF, 8'h10, mk(32'h0F, 32'h0F, 1'b0, 1'b0, 9));
    issue8(ALU_DIV, 8'd200, 8'd3, mk(32'h42, 32'h02, 1'b0, 1'b0, 9));
    issue8(ALU_DIV, 8'd5, 8'd9, mk(32'h00, 32'h05, 1'b0, 1'b0, 9));
    issue8(ALU_DIV, 8'h80, 8'h80, mk(32'h01, 32'h00, 1'b0, 1'b0, 9));

    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    chk("w32_pending", 32'(q32.size()), 32'd0);
    chk("w8_pending", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, multi-cycle successor to the processor's ALU control path. Accepts a 4-bit ALU operation code with two operands and executes it. Single-cycle operations are add, sub, not-equal, greater, less and AND. MULT (shift-add) and DIV (restoring) are iterative. Sits between the control unit and the register-file writeback, with a start/busy/done handshake so the controller can stall on long operations.

## Interface
- WIDTH, 32, operand and result-half width (≥ 2)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  4  operation code (encodings below)
- a  in  WIDTH  operand A (dividend / multiplicand)
- b  in  WIDTH  operand B (divisor / multiplier)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; results valid from this cycle
- result_lo  out  WIDTH  low result / quotient
- result_hi  out  WIDTH  high product / remainder; 0 for single-cycle ops
- div_by_zero  out  1  sticky flag for the last completed op
- invalid_op  out  1  sticky flag for the last completed op

## Operation
- Op codes (unsigned throughout):
  - 0000 ADD, lo = a+b mod 2^WIDTH
  - 0001 SUB, lo = a−b mod 2^WIDTH
  - 0010 NE, lo = (a≠b)
  - 0011 GT, lo = (a>b)
  - 0100 LT, lo = (a<b)
  - 0110 AND, lo = a&b
  - 1000 MULT, {hi,lo} = a*b (full 2·WIDTH product)
  - 1001 DIV, lo = a/b, hi = a%b
- Any other code: lo = all-ones, hi = 0, invalid_op = 1.
- States: IDLE, MUL, DIV, DONE.
  - IDLE & start & single-cycle/invalid op → DONE, result registered.
  - IDLE & start & MULT → MUL; & DIV with b≠0 → DIV.
  - IDLE & start & DIV with b=0 → DONE with lo = all-ones, hi = a, div_by_zero = 1.
  - MUL/DIV → DONE once counter reaches WIDTH.
  - DONE → IDLE unconditionally.
- a, b and op are latched on acceptance. Later input changes do not affect the op in flight.
- start outside IDLE is ignored (not queued).
- Flags and results update only on entry to DONE and hold until the next DONE.
- MUL step: if multiplier LSB is set, add multiplicand to upper accumulator. Then shift {carry,acc} right 1.
- DIV step: shift {rem,quot} left 1, trial-subtract b from rem, restore on borrow, set quotient bit on success.

## Timing
- Reset: state = IDLE, counter = 0, busy = done = 0, result_lo = result_hi = 0, both flags 0.
- Start accepted at cycle t (IDLE, start = 1).
  - Single-cycle, invalid and div-by-zero: done = 1 at t+1.
  - MULT/DIV: WIDTH iteration cycles t+1…t+WIDTH, done = 1 at t+WIDTH+1.
- busy = 1 from t+1 through the DONE cycle inclusive; 0 in IDLE.
- Earliest next acceptance is the cycle after done, so single-cycle throughput is one op per 2 cycles.
- Reset mid-operation aborts the op: next cycle IDLE with every output at its reset value, and no done pulse.
- start and reset high together: reset wins.

## Structure
- Shared package alu_pkg:
  - op-code localparams (ALU_ADD … ALU_DIV)
  - state enum typedef
  - the invalid-result constant
- One sub-module, alu_iter_core: holds the accumulator/remainder and shift register and performs one MUL or DIV step per cycle on an enable. The parent owns the FSM, counter, single-cycle ops and output registers.

## Test plan
- ADD, WIDTH = 32, a = 0xFFFFFFFF, b = 2, start at t → done at t+1, lo = 0x00000001, hi = 0, busy high only at t+1.
- MULT a = 0xFFFFFFFF, b = 0xFFFFFFFF → done at t+33, hi = 0xFFFFFFFE, lo = 0x00000001. start pulses during busy are ignored, with exactly one done.
- DIV a = 100, b = 7 → done at t+33, lo = 14, hi = 2. Follow with DIV b = 0, a = 5 → done at t+1, lo = 0xFFFFFFFF, hi = 5, div_by_zero = 1.
- op = 0101, then LT a = 3, b = 9 → first done: invalid_op = 1, lo = 0xFFFFFFFF. Second done: invalid_op = 0, lo = 1.
- Reset asserted at t+10 of a MULT → at t+11 state IDLE, all outputs 0, no done. A fresh ADD 1+1 then completes with lo = 2.
- Repeat MULT/DIV random regression with WIDTH = 8 against a reference model: latency is exactly 9 cycles for every MULT/DIV.
